writeback_unit: RTL

- Final pipeline stage of the 16-bit CPU, directly upstream of the 16x16 register bank.
- Merges ALU results and load results into the bank's single write port (reg_data / write_reg / r_w), at most one write per clock.
- Buffers colliding results in a small in-order queue and tells issue to stall.
- Offers forwarding of pending writes: the bank commits on posedge, so a same-cycle read returns the old value.

---
 rtl/wb_pkg.sv | 21 ++
 rtl/writeback_unit_if.sv | 39 +++
 rtl/wb_queue.sv | 98 +++++++++
 rtl/writeback_unit.sv | 123 ++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared types and constants for the writeback stage.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package wb_pkg;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 4;

    // One pending register write
    typedef struct packed {
        logic [ADDR_W-1:0] dest;
        logic [DATA_W-1:0] data;
    } wb_entry_t;

    // Which source feeds the WB register this cycle
    localparam logic [1:0] SRC_NONE = 2'd0;
    localparam logic [1:0] SRC_Q    = 2'd1;
    localparam logic [1:0] SRC_MEM  = 2'd2;
    localparam logic [1:0] SRC_ALU  = 2'd3;

endpackage

// File: rtl/writeback_unit_if.sv
// Result inputs, register-bank write port, status and forwarding lookups.
// Latency: n/a (wires only).
// Backpressure: stall tells issue to hold ALU producers; mem is never held.
interface writeback_unit_if;
    import wb_pkg::*;

    logic              alu_valid;
    logic [ADDR_W-1:0] alu_dest;
    logic [DATA_W-1:0] alu_data;
    logic              mem_valid;
    logic [ADDR_W-1:0] mem_dest;
    logic [DATA_W-1:0] mem_data;
    logic [DATA_W-1:0] reg_data;
    logic [ADDR_W-1:0] write_reg;
    logic              r_w;
    logic              stall;
    logic              overflow;
    logic [ADDR_W-1:0] fwd_addr_a;
    logic [ADDR_W-1:0] fwd_addr_b;
    logic              fwd_hit_a;
    logic [DATA_W-1:0] fwd_data_a;
    logic              fwd_hit_b;
    logic [DATA_W-1:0] fwd_data_b;

    modport slave (
        input  alu_valid, alu_dest, alu_data, mem_valid, mem_dest, mem_data,
        input  fwd_addr_a, fwd_addr_b,
        output reg_data, write_reg, r_w, stall, overflow,
        output fwd_hit_a, fwd_data_a, fwd_hit_b, fwd_data_b
    );

    modport master (
        output alu_valid, alu_dest, alu_data, mem_valid, mem_dest, mem_data,
        output fwd_addr_a, fwd_addr_b,
        input  reg_data, write_reg, r_w, stall, overflow,
        input  fwd_hit_a, fwd_data_a, fwd_hit_b, fwd_data_b
    );

endinterface

// File: rtl/wb_queue.sv
// Collision queue: in-order FIFO, 2 pushes + 1 pop per clock, youngest-first lookup on two addresses.
// Latency: push visible at head/lookup the cycle after it is written.
// Backpressure: none; pushes beyond capacity are rejected youngest-first and flagged on o_drop.
module wb_queue
    import wb_pkg::*;
#(
    parameter int QDEPTH = 2,
    localparam int CNT_W = $clog2(QDEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_push0_vld,
    input  wb_entry_t         i_push0_dat,
    input  logic              i_push1_vld,
    input  wb_entry_t         i_push1_dat,
    input  logic              i_pop,
    output wb_entry_t         o_head_dat,
    output logic [CNT_W-1:0]  o_count,
    output logic [CNT_W-1:0]  o_next_count,
    output logic              o_drop,
    input  logic [ADDR_W-1:0] i_addr_a,
    output logic              o_hit_a,
    output logic [DATA_W-1:0] o_data_a,
    input  logic [ADDR_W-1:0] i_addr_b,
    output logic              o_hit_b,
    output logic [DATA_W-1:0] o_data_b
);

    wb_entry_t        r_q [QDEPTH];
    logic [CNT_W-1:0] r_count;

    wb_entry_t        w_q_nxt [QDEPTH];
    logic [CNT_W-1:0] w_free;
    logic [CNT_W-1:0] w_base;
    logic [CNT_W-1:0] w_slot1;
    logic             w_acc0;
    logic             w_acc1;

    // Entry 0 is always the head; pop shifts down, pushes land just above the survivors
    always_comb begin
        w_free  = CNT_W'(QDEPTH) - r_count + CNT_W'(i_pop);
        w_acc0  = i_push0_vld && (w_free != '0);
        w_acc1  = i_push1_vld && (w_free > CNT_W'(i_push0_vld));
        w_base  = r_count - CNT_W'(i_pop);
        w_slot1 = w_base + CNT_W'(w_acc0);
        w_q_nxt = r_q;
        if (i_pop) begin
            for (int i = 0; i < QDEPTH - 1; i++) begin
                w_q_nxt[i] = r_q[i + 1];
            end
        end
        for (int i = 0; i < QDEPTH; i++) begin
            if (w_acc0 && (CNT_W'(i) == w_base)) begin
                w_q_nxt[i] = i_push0_dat;
            end
            if (w_acc1 && (CNT_W'(i) == w_slot1)) begin
                w_q_nxt[i] = i_push1_dat;
            end
        end
        o_next_count = w_base + CNT_W'(w_acc0) + CNT_W'(w_acc1);
        o_drop       = (i_push0_vld && !w_acc0) || (i_push1_vld && !w_acc1);
    end

    // Queue storage and occupancy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
            for (int i = 0; i < QDEPTH; i++) begin
                r_q[i] <= '0;
            end
        end else begin
            r_count <= o_next_count;
            r_q     <= w_q_nxt;
        end
    end

    // Scan head to tail so the youngest valid match is the one left standing
    always_comb begin
        o_hit_a  = 1'b0;
        o_data_a = '0;
        o_hit_b  = 1'b0;
        o_data_b = '0;
        for (int i = 0; i < QDEPTH; i++) begin
            if ((CNT_W'(i) < r_count) && (r_q[i].dest == i_addr_a)) begin
                o_hit_a  = 1'b1;
                o_data_a = r_q[i].data;
            end
            if ((CNT_W'(i) < r_count) && (r_q[i].dest == i_addr_b)) begin
                o_hit_b  = 1'b1;
                o_data_b = r_q[i].data;
            end
        end
    end

    assign o_head_dat = r_q[0];
    assign o_count    = r_count;

endmodule

// File: rtl/writeback_unit.sv
// Merges ALU and load results into the single bank write port, queueing collisions in program order.
// Latency: 1 cycle from arrival to r_w for an uncontended result; 1 write/cycle sustained.
// Backpressure: registered stall when the queue is near full; excess arrivals dropped and overflow latched.
module writeback_unit
    import wb_pkg::*;
#(
    parameter int QDEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    writeback_unit_if.slave  bus
);

    localparam int CNT_W = $clog2(QDEPTH + 1);

    logic              r_wb_vld;
    wb_entry_t         r_wb;
    logic              r_stall;
    logic              r_overflow;

    logic [1:0]        w_sel;
    logic              w_push0_vld;
    wb_entry_t         w_push0_dat;
    logic              w_push1_vld;
    wb_entry_t         w_mem;
    wb_entry_t         w_alu;
    wb_entry_t         w_head;
    wb_entry_t         w_wb_nxt;
    logic [CNT_W-1:0]  w_count;
    logic [CNT_W-1:0]  w_next_count;
    logic              w_drop;
    logic              w_q_hit_a;
    logic              w_q_hit_b;
    logic [DATA_W-1:0] w_q_data_a;
    logic [DATA_W-1:0] w_q_data_b;
    logic              w_wb_hit_a;
    logic              w_wb_hit_b;

    assign w_mem = '{dest: bus.mem_dest, data: bus.mem_data};
    assign w_alu = '{dest: bus.alu_dest, data: bus.alu_data};

    // Oldest item wins the write port: queue head, then mem, then alu; the rest queue in age order
    always_comb begin
        w_sel = SRC_NONE;
        if (w_count != '0) begin
            w_sel = SRC_Q;
        end else if (bus.mem_valid) begin
            w_sel = SRC_MEM;
        end else if (bus.alu_valid) begin
            w_sel = SRC_ALU;
        end
        w_wb_nxt    = '0;
        w_push0_vld = 1'b0;
        w_push0_dat = w_alu;
        w_push1_vld = 1'b0;
        case (w_sel)
            SRC_Q: begin
                w_wb_nxt    = w_head;
                w_push0_vld = bus.mem_valid;
                w_push0_dat = w_mem;
                w_push1_vld = bus.alu_valid;
            end
            SRC_MEM: begin
                w_wb_nxt    = w_mem;
                w_push0_vld = bus.alu_valid;
            end
            SRC_ALU: w_wb_nxt = w_alu;
            default: w_wb_nxt = '0;
        endcase
    end

    wb_queue #(.QDEPTH(QDEPTH)) u_queue (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_push0_vld  (w_push0_vld),
        .i_push0_dat  (w_push0_dat),
        .i_push1_vld  (w_push1_vld),
        .i_push1_dat  (w_alu),
        .i_pop        (w_sel == SRC_Q),
        .o_head_dat   (w_head),
        .o_count      (w_count),
        .o_next_count (w_next_count),
        .o_drop       (w_drop),
        .i_addr_a     (bus.fwd_addr_a),
        .o_hit_a      (w_q_hit_a),
        .o_data_a     (w_q_data_a),
        .i_addr_b     (bus.fwd_addr_b),
        .o_hit_b      (w_q_hit_b),
        .o_data_b     (w_q_data_b)
    );

    // WB register, registered stall and sticky overflow
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wb_vld   <= 1'b0;
            r_wb       <= '0;
            r_stall    <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_wb_vld   <= (w_sel != SRC_NONE);
            r_wb       <= w_wb_nxt;
            r_stall    <= (w_next_count >= CNT_W'(QDEPTH - 1));
            r_overflow <= r_overflow || w_drop;
        end
    end

    // Queue entries are younger than WB, so a queue hit overrides a WB hit
    always_comb begin
        w_wb_hit_a = r_wb_vld && (r_wb.dest == bus.fwd_addr_a);
        w_wb_hit_b = r_wb_vld && (r_wb.dest == bus.fwd_addr_b);
    end

    assign bus.r_w        = r_wb_vld;
    assign bus.write_reg  = r_wb.dest;
    assign bus.reg_data   = r_wb.data;
    assign bus.stall      = r_stall;
    assign bus.overflow   = r_overflow;
    assign bus.fwd_hit_a  = w_q_hit_a || w_wb_hit_a;
    assign bus.fwd_data_a = w_q_hit_a ? w_q_data_a : (w_wb_hit_a ? r_wb.data : '0);
    assign bus.fwd_hit_b  = w_q_hit_b || w_wb_hit_b;
    assign bus.fwd_data_b = w_q_hit_b ? w_q_data_b : (w_wb_hit_b ? r_wb.data : '0);

endmodule
